// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU result path: FP32 field layout,
// special exponent value, transmitter state type and frame lengths.
package fp_alu_pkg;

    // FP32 field positions
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_MSB = 22;
    localparam int FP_MANT_W   = 23;

    // Exponent value shared by infinities and NaNs
    localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    // Frame lengths in bytes: plain word, and word plus status byte
    localparam int FRAME_BYTES_BASE  = 4;
    localparam int FRAME_BYTES_FLAGS = 5;

    // Transmitter states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 classifier producing the frame status byte
// {4'b0000, is_nan, is_inf, is_zero, sign}. Denormals are not zero.
module fp_classify
    import fp_alu_pkg::*;
(
    input  logic [31:0] word,
    output logic [7:0]  status
);

    logic [FP_EXP_W-1:0]  exp_f;
    logic [FP_MANT_W-1:0] mant_f;

    assign exp_f  = word[FP_EXP_MSB:FP_EXP_LSB];
    assign mant_f = word[FP_MANT_MSB:0];

    // Build status flags from the exponent/mantissa fields
    always_comb begin
        status    = 8'h00;
        status[3] = (exp_f == EXP_ALL_ONES) && (mant_f != '0);
        status[2] = (exp_f == EXP_ALL_ONES) && (mant_f == '0);
        status[1] = (exp_f == '0) && (mant_f == '0);
        status[0] = word[FP_SIGN_BIT];
    end

endmodule

// File: rtl/fp_result_tx.sv
// FP result transmitter: accepts one 32-bit FP word and sends it MSB first
// as a byte-wide frame with a valid/ack handshake.
// Optional macro FP_TX_FLAGS_EN appends a fifth status byte from fp_classify.
//
// Handshakes: a word is taken on a rising edge where in_valid && in_ready;
// a byte is consumed on a rising edge where out_valid && out_ack. out_byte
// and out_valid stay stable until consumed; out_ack is don't-care while
// out_valid is low, and in_valid is don't-care while in_ready is low.
module fp_result_tx
    import fp_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        out_last,
    output logic        busy,
    output logic [0:0]  state_dbg
);

`ifdef FP_TX_FLAGS_EN
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES_FLAGS - 1);
`else
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES_BASE - 1);
`endif

    tx_state_t   state;
    tx_state_t   next_state;
    logic [2:0]  cnt;
    logic [31:0] word;
    logic        load;
    logic        advance;
    logic [7:0]  status_byte;

`ifdef FP_TX_FLAGS_EN
    fp_classify u_classify (
        .word   (word),
        .status (status_byte)
    );
`else
    assign status_byte = 8'h00;
`endif

    // State, byte index and latched word registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            word  <= 32'h0;
        end else begin
            state <= next_state;
            if (load) begin
                word <= in_data;
                cnt  <= 3'd0;
            end else if (advance) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Next-state logic: accept in IDLE, step through bytes on ack in SEND
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = SEND;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (out_ack) begin
                    if (cnt == LAST_IDX) begin
                        next_state = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: byte mux is zeroed whenever no byte is presented
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == SEND);
        out_valid = (state == SEND);
        out_last  = (state == SEND) && (cnt == LAST_IDX);
        out_byte  = 8'h00;
        if (state == SEND) begin
            case (cnt)
                3'd0:    out_byte = word[31:24];
                3'd1:    out_byte = word[23:16];
                3'd2:    out_byte = word[15:8];
                3'd3:    out_byte = word[7:0];
                3'd4:    out_byte = status_byte;
                default: out_byte = 8'h00;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fp_result_tx.sv
// Testbench for fp_result_tx. Honours FP_TX_FLAGS_EN the same way as the RTL.
module tb_fp_result_tx;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ack;
    logic        out_last;
    logic        busy;
    logic [0:0]  state_dbg;

    int n_tests;
    int n_fail;

    logic [7:0] exp_q[$];

    fp_result_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_last  (out_last),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          mode;       // 0: ack every cycle, 1: ack 1-of-3, 2: random
        logic [39:0] exp_frame;  // four data bytes then status byte
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: status byte from the FP32 classification rules
    function automatic logic [7:0] model_status(input logic [31:0] w);
        int e, m, s, v;
        e = int'((w >> 23) & 32'hFF);
        m = int'(w & 32'h007F_FFFF);
        s = int'(w >> 31);
        v = 0;
        if (e == 255 && m != 0) v += 8;
        if (e == 255 && m == 0) v += 4;
        if (e == 0 && m == 0)   v += 2;
        v += s;
        return 8'(v);
    endfunction

    // Queue the expected frame for a word using the model
    task automatic push_model(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
`ifdef FP_TX_FLAGS_EN
        exp_q.push_back(model_status(w));
`endif
    endtask

    // Queue an expected frame from a table entry
    task automatic push_table(input logic [39:0] f);
        exp_q.push_back(f[39:32]);
        exp_q.push_back(f[31:24]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[15:8]);
`ifdef FP_TX_FLAGS_EN
        exp_q.push_back(f[7:0]);
`endif
    endtask

    // Driver: present a word at the current negedge
    task automatic offer(input logic [31:0] w);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        in_data  = w;
        in_valid = 1'b1;
    endtask

    // Drain the frame in progress, checking each presented byte against exp_q
    task automatic drain(input int mode, input bit keep_valid);
        int k;
        bit ack;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (!keep_valid) in_valid = 1'b0;
            check("out_valid", 32'(out_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("in_ready_send", 32'(in_ready), 32'd0);
            check("out_byte", 32'(out_byte), 32'(exp_q[0]));
            check("out_last", 32'(out_last), (exp_q.size() == 1) ? 32'd1 : 32'd0);
            case (mode)
                0:       ack = 1'b1;
                1:       ack = ((k % 3) == 2);
                default: ack = ($urandom_range(0, 1) == 1);
            endcase
            out_ack = ack;
            if (ack) void'(exp_q.pop_front());
            k++;
            if (k > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_timeout: got %0d bytes left expected 0", exp_q.size());
                exp_q.delete();
            end
        end
        @(negedge clk);
        out_ack = 1'b0;
        check("end_out_valid", 32'(out_valid), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("end_out_byte", 32'(out_byte), 32'd0);
        check("end_out_last", 32'(out_last), 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_data  = 32'h0;
        in_valid = 1'b0;
        out_ack  = 1'b0;

        vecs[0] = '{32'h3FC00000, 0, 40'h3F_C0_00_00_00};
        vecs[1] = '{32'h12345678, 1, 40'h12_34_56_78_00};
        vecs[2] = '{32'h7FC00000, 0, 40'h7F_C0_00_00_08};
        vecs[3] = '{32'hFF800000, 2, 40'hFF_80_00_00_05};
        vecs[4] = '{32'h80000000, 1, 40'h80_00_00_00_03};
        vecs[5] = '{32'h00000001, 0, 40'h00_00_00_01_00};

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // out_ack while nothing is presented must not start anything
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("ack_idle_out_valid", 32'(out_valid), 32'd0);
        check("ack_idle_in_ready", 32'(in_ready), 32'd1);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            push_table(vecs[i].exp_frame);
            offer(vecs[i].data);
            drain(vecs[i].mode, 1'b0);
        end

        // in_valid held high with a second word during a frame
        push_table(40'h3F_80_00_00_00);
        offer(32'h3F800000);
        @(negedge clk);
        in_data = 32'hDEADBEEF;
        check("hold_first_byte", 32'(out_byte), 32'h3F);
        out_ack = 1'b1;
        void'(exp_q.pop_front());
        drain(0, 1'b1);
        push_table(40'hDE_AD_BE_EF_00);
        drain(0, 1'b0);

        // Reset in the middle of a frame, then a fresh frame
        offer(32'h11223344);
        @(negedge clk);
        in_valid = 1'b0;
        out_ack  = 1'b1;
        @(negedge clk);
        check("mid_second_byte", 32'(out_byte), 32'h22);
        @(negedge clk);
        out_ack = 1'b0;
        check("mid_third_byte", 32'(out_byte), 32'h33);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_byte", 32'(out_byte), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("mid_rst_no_resume", 32'(out_valid), 32'd0);
        push_table(40'h40_49_0F_DB_00);
        offer(32'h40490FDB);
        drain(2, 1'b0);

        // Randomized frames against the model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] w;
            w = $urandom;
            case ($urandom_range(0, 5))
                0: w[30:23] = 8'hFF;
                1: begin w[30:23] = 8'hFF; w[22:0] = '0; end
                2: w[30:0] = '0;
                3: w[30:23] = 8'h00;
                default: ;
            endcase
            push_model(w);
            offer(w);
            drain(int'($urandom_range(0, 2)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_result_tx.md
FP_RESULT_TX -- requirements
Module: fp_result_tx

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_data  in  32  IEEE-754 single-precision result word from the FP ALU.
REQ-004 SHALL have ports: in_valid  in  1  in_data valid; in_ready  out  1  block can accept a word.
REQ-005 SHALL have ports: out_byte  out  8  current byte on the byte-wide output bus.
REQ-006 SHALL have ports: out_valid  out  1  out_byte valid; out_ack  in  1  host consumed out_byte.
REQ-007 SHALL have ports: out_last  out  1  high with the final byte of a frame; busy  out  1  frame in progress.

Function
REQ-008 SHALL implement states IDLE and SEND only.
REQ-009 SHALL drive in_ready = 1 exactly when state is IDLE; busy = 1 exactly when state is SEND.
REQ-010 SHALL, on a rising edge with in_valid && in_ready, latch in_data, clear the byte counter, and enter SEND.
- out_valid = 1 with the first byte the following cycle, giving 1-cycle latency.
REQ-011 SHALL ignore in_valid while in SEND.
- No latch, no state change, and the latched word is never overwritten mid-frame.
REQ-012 SHALL send bytes MSB first: in_data[31:24], [23:16], [15:8], [7:0].
REQ-013 SHALL hold out_byte and out_valid = 1 stable in SEND until a rising edge with out_ack = 1.
REQ-014 SHALL, on each acked non-final byte, present the next byte the next cycle with no idle gap.
- out_ack held high continuously yields one byte per cycle.
REQ-015 SHALL ignore out_ack while out_valid = 0.
REQ-016 SHALL drive out_last = 1 only while the final byte of the frame is presented.
REQ-017 SHALL, on the ack of the final byte, return to IDLE.
- out_valid = 0 and in_ready = 1 the next cycle.
- A new word accepted in that cycle yields out_valid = 1 the cycle after; minimum frame spacing is one idle cycle.
REQ-018 SHALL use a 3-bit byte counter; the final index is 3, or 4 with REQ-023; the counter never wraps past the final index.
REQ-019 SHALL drive out_byte = 8'h00 whenever out_valid = 0.

Reset
REQ-020 SHALL, while rst = 1, immediately and asynchronously force:
- state = IDLE, counter = 0, latched word = 0;
- out_valid = 0, out_last = 0, busy = 0, out_byte = 8'h00.
REQ-021 SHALL abort a frame when reset occurs mid-frame; the frame is not resumed after reset.
REQ-022 SHALL drive in_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, with macro FP_TX_FLAGS_EN defined, append a fifth status byte after byte [7:0]; out_last moves to this byte.
- Status byte = {4'b0000, is_nan, is_inf, is_zero, sign}.
- is_nan: exp = 8'hFF and mantissa != 0.
- is_inf: exp = 8'hFF and mantissa = 0.
- is_zero: exp = 0 and mantissa = 0; denormals are not zero.
- sign: bit 31.
REQ-024 SHALL, without FP_TX_FLAGS_EN, send exactly 4-byte frames and instantiate no classification logic.

Structure
REQ-025 SHALL take from shared package fp_alu_pkg:
- FP32 field widths and positions (sign 31, exp 30:23, mantissa 22:0);
- EXP_ALL_ONES constant;
- state enum type;
- FRAME_BYTES constants (4 and 5).
REQ-026 SHALL place classification in sub-module fp_classify (combinational), instantiated only under FP_TX_FLAGS_EN.

Verification
REQ-027 SHALL cover: in_data 32'h3FC00000 with out_ack always 1 -> 3F,C0,00,00 on 4 consecutive cycles, out_last on 00, in_ready back high the next cycle.
REQ-028 SHALL cover: out_ack toggled 1-of-3 cycles for 32'h12345678 -> each byte held stable until acked, order 12,34,56,78, no duplicates.
REQ-029 SHALL cover, with FP_TX_FLAGS_EN:
- 32'h7FC00000 -> status byte 8'h08;
- 32'hFF800000 -> 8'h05;
- 32'h80000000 -> 8'h03;
- 32'h00000001 -> 8'h00.
REQ-030 SHALL cover: in_valid held high with 32'hDEADBEEF during the frame of 32'h3F800000 -> frame is 3F,80,00,00 and DEADBEEF is accepted only after return to IDLE.
REQ-031 SHALL cover: rst pulsed after the second byte is acked -> out_valid drops in the same cycle; after release in_ready = 1 and a new frame of 32'h40490FDB starts with byte 40.
